directory_req_sched: RTL and testbench
======================================

// Module: directory_req_sched
// PURPOSE
//   Front-end scheduler of the coherence directory. Arbitrates the I$ request queue, D$ request queue
//   and memory reply queue, reads the directory state for the chosen line, and presents exactly one
//   decoded transaction per grant to directory_gen_request. Tracks one outstanding memory miss,
//   blocking conflicting requests until its REPLY returns.
// PARAMETERS
//   ADDR_W   32    line address width
//   TIMEOUT  1024  cycles a pending miss may wait for REPLY before err_timeout
// PORTS
//   clk             in   1       clock
//   rst             in   1       reset, asynchronous, active-high
//   ic_req_valid    in   1       I$ queue head valid
//   ic_req_op       in   3       I$ opcode (NOOP0 REPLY2 RD3 WR4 INV5 UPD6 RWITM7)
//   ic_req_addr     in   ADDR_W  I$ line address
//   ic_req_pop      out  1       1-cycle pop of I$ head
//   dc_req_valid/op/addr/pop     same as ic_* for D$ queue
//   mem_rsp_valid   in   1       memory reply head valid (opcode implicitly REPLY)
//   mem_rsp_addr    in   ADDR_W  reply line address
//   mem_rsp_pop     out  1       1-cycle pop of reply head
//   dir_rd_en       out  1       directory lookup strobe
//   dir_rd_addr     out  ADDR_W  lookup address
//   dir_rd_state    in   4       {D$[1:0],I$[1:0]} state; valid cycle after dir_rd_en (S=1, M=2)
//   gen_valid       out  1       transaction strobe to directory_gen_request
//   gen_operation   out  3       opcode;  gen_source out 2 / gen_dest out 2  (I$=1 D$=2 MEM=3)
//   gen_state       out  4       latched dir_rd_state;  gen_addr out ADDR_W line address
//   pend_valid      out  1       memory miss outstanding
//   err_timeout     out  1       sticky: pending miss exceeded TIMEOUT
//   err_stray       out  1       sticky: REPLY without matching pending miss
// BEHAVIOUR
//   - Reset (async): FSM=IDLE, rr_ptr=I$, pend cleared, timer 0, all outputs 0.
//   - FSM IDLE->LOOKUP->ISSUE->IDLE; one grant per 3 cycles, no overlap.
//   - IDLE: grant priority MEM reply > round-robin(I$,D$). In grant cycle: pulse *_pop, dir_rd_en=1,
//     dir_rd_addr=addr; latch op/addr/source; ->LOOKUP. No eligible requester: stay IDLE.
//   - Masking while pend_valid: cache request masked if op in {RD,RWITM} or addr==pend_addr.
//   - rr_ptr toggles to other cache after a cache grant; unchanged on MEM grant.
//   - LOOKUP: latch dir_rd_state ->ISSUE.
//   - ISSUE: gen_valid=1 for exactly one cycle with registered fields; ->IDLE. Dest rules:
//     RD/RWITM: other cache state!=0 -> dest=other cache, else dest=MEM and set pend
//       (pend_addr, pend_src=source, timer=0).
//     UPD -> dest=other cache; WR/INV -> dest=MEM; REPLY -> source=MEM, dest=pend_src.
//     NOOP: popped, no gen_valid, ->IDLE.
//   - REPLY with pend_valid && addr==pend_addr clears pend in ISSUE; else err_stray=1, gen_dest=0.
//   - Timer: increments each cycle while pend_valid, saturates; reaching TIMEOUT sets err_timeout.
//   - Reply clearing pend on the same cycle a new miss would set it: cannot occur (serialized FSM).
//   - Errors clear only on rst. Async rst mid-LOOKUP/ISSUE aborts: no gen_valid, popped entry lost.
// STRUCTURE
//   - dir_pkg: opcode localparams, source codes (IC=1,DC=2,MEM=3), line states (S=1,M=2),
//     FSM state enum. Shared with directory_gen_request.
//   - Sub-module dir_rr_arb2: 2-way round-robin with per-requester mask, returns grant + next ptr.
// TESTING
//   1. Assert rst mid-run -> all outputs 0 immediately, FSM IDLE, pend_valid=0.
//   2. I$ RD 0x40, dir_rd_state=4'b0000 -> pop/dir_rd_en cyc0, gen_valid cyc2 op=3 src=1 dest=3, pend_valid=1.
//   3. I$ and D$ valid together after reset -> I$ granted cyc0, D$ granted cyc3; with D$ state 4'b0100,
//      I$ RD gives dest=2 and no pend.
//   4. pend 0x40; D$ RD 0x80 and D$ UPD 0x80 queued; mem_rsp 0x40 valid -> REPLY first (src3 dest1,
//      pend clears), RD no longer masked afterward.
//   5. TIMEOUT=8, pending miss, no reply -> err_timeout=1 exactly 8 cycles after pend set; stays 1.
//   6. mem_rsp 0x99 with no pend -> gen_valid op=2 dest=0, err_stray=1.

Source files
------------

// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - opcodes, agent codes, line states and FSM states shared by the directory front end
package dir_pkg;

   localparam logic [2:0] OP_NOOP  = 3'd0;
   localparam logic [2:0] OP_REPLY = 3'd2;
   localparam logic [2:0] OP_RD    = 3'd3;
   localparam logic [2:0] OP_WR    = 3'd4;
   localparam logic [2:0] OP_INV   = 3'd5;
   localparam logic [2:0] OP_UPD   = 3'd6;
   localparam logic [2:0] OP_RWITM = 3'd7;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_IC   = 2'd1;
   localparam logic [1:0] SRC_DC   = 2'd2;
   localparam logic [1:0] SRC_MEM  = 2'd3;

   localparam logic [1:0] LS_I = 2'd0;
   localparam logic [1:0] LS_S = 2'd1;
   localparam logic [1:0] LS_M = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_ISSUE  = 2'd2
   } sched_state_t;

   // Opcodes that may need a memory fill and therefore open a pending miss.
   function automatic logic is_miss_op(input logic [2:0] op);
      return (op == OP_RD) || (op == OP_RWITM);
   endfunction

endpackage

// File: rtl/dir_rr_arb2.sv
// rtl/dir_rr_arb2.sv - two-way round-robin arbiter with per-requester mask
module dir_rr_arb2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       next_ptr
);

   logic [1:0] eligible;

   assign eligible = req & ~mask;

   // ptr names the preferred requester; the winner hands priority to the other side.
   always_comb begin
      grant    = 2'b00;
      next_ptr = ptr;
      if (eligible[ptr]) begin
         grant[ptr] = 1'b1;
         next_ptr   = ~ptr;
      end else if (eligible[~ptr]) begin
         grant[~ptr] = 1'b1;
         next_ptr    = ptr;
      end
   end

endmodule

// File: rtl/directory_req_sched.sv
// rtl/directory_req_sched.sv - directory front-end scheduler: arbitrate, look up, issue one transaction per grant
module directory_req_sched
   import dir_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_valid,
   input  logic [2:0]        ic_req_op,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_pop,
   input  logic              dc_req_valid,
   input  logic [2:0]        dc_req_op,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_pop,
   input  logic              mem_rsp_valid,
   input  logic [ADDR_W-1:0] mem_rsp_addr,
   output logic              mem_rsp_pop,
   output logic              dir_rd_en,
   output logic [ADDR_W-1:0] dir_rd_addr,
   input  logic [3:0]        dir_rd_state,
   output logic              gen_valid,
   output logic [2:0]        gen_operation,
   output logic [1:0]        gen_source,
   output logic [1:0]        gen_dest,
   output logic [3:0]        gen_state,
   output logic [ADDR_W-1:0] gen_addr,
   output logic              pend_valid,
   output logic              err_timeout,
   output logic              err_stray
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   sched_state_t      state, state_nxt;
   logic              rr_ptr;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        src_q;
   logic [3:0]        line_q;
   logic [ADDR_W-1:0] pend_addr;
   logic [1:0]        pend_src;
   logic [TMR_W-1:0]  timer;

   logic [1:0]        cache_mask;
   logic [1:0]        arb_grant;
   logic              arb_next_ptr;
   logic              take, rr_upd;
   logic [2:0]        take_op;
   logic [1:0]        take_src;
   logic [ADDR_W-1:0] take_addr;
   logic [1:0]        other_state, other_cache;
   logic              pend_set, pend_clr, stray_set;

   // While a miss is open, block further misses and anything touching the pending line.
   assign cache_mask[0] = pend_valid && (is_miss_op(ic_req_op) || (ic_req_addr == pend_addr));
   assign cache_mask[1] = pend_valid && (is_miss_op(dc_req_op) || (dc_req_addr == pend_addr));

   dir_rr_arb2 u_arb (
      .req      ({dc_req_valid, ic_req_valid}),
      .mask     (cache_mask),
      .ptr      (rr_ptr),
      .grant    (arb_grant),
      .next_ptr (arb_next_ptr)
   );

   always_comb begin
      state_nxt   = state;
      ic_req_pop  = 1'b0;
      dc_req_pop  = 1'b0;
      mem_rsp_pop = 1'b0;
      dir_rd_en   = 1'b0;
      dir_rd_addr = '0;
      take        = 1'b0;
      rr_upd      = 1'b0;
      take_op     = OP_NOOP;
      take_src    = SRC_NONE;
      take_addr   = '0;
      case (state)
         ST_IDLE: begin
            if (!rst) begin
               if (mem_rsp_valid) begin
                  mem_rsp_pop = 1'b1;
                  take        = 1'b1;
                  take_op     = OP_REPLY;
                  take_src    = SRC_MEM;
                  take_addr   = mem_rsp_addr;
               end else if (arb_grant[0]) begin
                  ic_req_pop = 1'b1;
                  take       = 1'b1;
                  rr_upd     = 1'b1;
                  take_op    = ic_req_op;
                  take_src   = SRC_IC;
                  take_addr  = ic_req_addr;
               end else if (arb_grant[1]) begin
                  dc_req_pop = 1'b1;
                  take       = 1'b1;
                  rr_upd     = 1'b1;
                  take_op    = dc_req_op;
                  take_src   = SRC_DC;
                  take_addr  = dc_req_addr;
               end
            end
            dir_rd_en   = take;
            dir_rd_addr = take_addr;
            if (take) state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: state_nxt = ST_ISSUE;
         ST_ISSUE:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign other_state = (src_q == SRC_IC) ? line_q[3:2] : line_q[1:0];
   assign other_cache = (src_q == SRC_IC) ? SRC_DC : SRC_IC;

   always_comb begin
      gen_valid = 1'b0;
      gen_dest  = SRC_NONE;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      stray_set = 1'b0;
      if (state == ST_ISSUE) begin
         gen_valid = (op_q != OP_NOOP);
         case (op_q)
            OP_RD, OP_RWITM: begin
               if (other_state != LS_I) begin
                  gen_dest = other_cache;
               end else begin
                  gen_dest = SRC_MEM;
                  pend_set = 1'b1;
               end
            end
            OP_UPD:        gen_dest = other_cache;
            OP_WR, OP_INV: gen_dest = SRC_MEM;
            OP_REPLY: begin
               if (pend_valid && (addr_q == pend_addr)) begin
                  gen_dest = pend_src;
                  pend_clr = 1'b1;
               end else begin
                  stray_set = 1'b1;
               end
            end
            default: gen_dest = SRC_NONE;
         endcase
      end
   end

   assign gen_operation = op_q;
   assign gen_source    = src_q;
   assign gen_state     = line_q;
   assign gen_addr      = addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         rr_ptr <= 1'b0;
         op_q   <= OP_NOOP;
         addr_q <= '0;
         src_q  <= SRC_NONE;
         line_q <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            op_q   <= take_op;
            addr_q <= take_addr;
            src_q  <= take_src;
         end
         if (rr_upd) rr_ptr <= arb_next_ptr;
         if (state == ST_LOOKUP) line_q <= dir_rd_state;
      end
   end

   // Timer saturates at TIMEOUT; the error fires on the edge where it reaches TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_addr   <= '0;
         pend_src    <= SRC_NONE;
         timer       <= '0;
         err_timeout <= 1'b0;
         err_stray   <= 1'b0;
      end else begin
         if (pend_set) begin
            pend_valid <= 1'b1;
            pend_addr  <= addr_q;
            pend_src   <= src_q;
            timer      <= '0;
         end else if (pend_clr) begin
            pend_valid <= 1'b0;
            timer      <= '0;
         end else if (pend_valid && (timer != TMR_W'(TIMEOUT))) begin
            timer <= timer + 1'b1;
         end
         if (pend_valid && (timer >= TMR_W'(TIMEOUT - 1))) err_timeout <= 1'b1;
         if (stray_set) err_stray <= 1'b1;
      end
   end

endmodule

// File: tb/tb_directory_req_sched.sv
// tb/tb_directory_req_sched.sv - directed self-checking bench for directory_req_sched
module tb_directory_req_sched;
   import dir_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_req_valid, dc_req_valid, mem_rsp_valid;
   logic [2:0]  ic_req_op, dc_req_op;
   logic [31:0] ic_req_addr, dc_req_addr, mem_rsp_addr;
   logic        ic_req_pop, dc_req_pop, mem_rsp_pop;
   logic        dir_rd_en;
   logic [31:0] dir_rd_addr;
   logic [3:0]  dir_rd_state;
   logic        gen_valid;
   logic [2:0]  gen_operation;
   logic [1:0]  gen_source, gen_dest;
   logic [3:0]  gen_state;
   logic [31:0] gen_addr;
   logic        pend_valid, err_timeout, err_stray;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   directory_req_sched #(.ADDR_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_op(ic_req_op), .ic_req_addr(ic_req_addr), .ic_req_pop(ic_req_pop),
      .dc_req_valid(dc_req_valid), .dc_req_op(dc_req_op), .dc_req_addr(dc_req_addr), .dc_req_pop(dc_req_pop),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_pop(mem_rsp_pop),
      .dir_rd_en(dir_rd_en), .dir_rd_addr(dir_rd_addr), .dir_rd_state(dir_rd_state),
      .gen_valid(gen_valid), .gen_operation(gen_operation), .gen_source(gen_source),
      .gen_dest(gen_dest), .gen_state(gen_state), .gen_addr(gen_addr),
      .pend_valid(pend_valid), .err_timeout(err_timeout), .err_stray(err_stray)
   );

   task automatic drive_idle();
      ic_req_valid = 1'b0; ic_req_op = OP_NOOP; ic_req_addr = '0;
      dc_req_valid = 1'b0; dc_req_op = OP_NOOP; dc_req_addr = '0;
      mem_rsp_valid = 1'b0; mem_rsp_addr = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive_idle();
      dir_rd_state = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      rst = 1'b1;
      drive_idle();
      dir_rd_state = 4'b0000;
      ic_req_valid = 1'b1; ic_req_op = OP_RD; ic_req_addr = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_fsm: got %0d expected %0d", dut.state, ST_IDLE); end
      checks++; if ({ic_req_pop, dir_rd_en, gen_valid, pend_valid, err_timeout, err_stray} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 000000", {ic_req_pop, dir_rd_en, gen_valid, pend_valid, err_timeout, err_stray}); end
      checks++; if ({gen_operation, gen_source, gen_dest, gen_state, gen_addr} !== '0) begin
         errors++; $display("FAIL reset_gen_fields: got %h expected 0", {gen_operation, gen_source, gen_dest, gen_state, gen_addr}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (ic_req_pop !== 1'b1) begin errors++; $display("FAIL mid_grant_pop: got %b expected 1", ic_req_pop); end
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      checks++; if (dut.state !== ST_IDLE || gen_valid !== 1'b0 || pend_valid !== 1'b0 || gen_operation !== 3'd0) begin
         errors++; $display("FAIL mid_reset_abort: got state=%0d gv=%b pend=%b op=%0d expected 0 0 0 0", dut.state, gen_valid, pend_valid, gen_operation); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (gen_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_issue: got %b expected 0", seen); end
   endtask

   task automatic test_miss();
      apply_reset();
      @(negedge clk);
      ic_req_valid = 1'b1; ic_req_op = OP_RD; ic_req_addr = 32'h40;
      #1;
      checks++; if ({ic_req_pop, dir_rd_en} !== 2'b11 || dir_rd_addr !== 32'h40) begin
         errors++; $display("FAIL miss_cyc0: got pop/en=%b addr=%h expected 11 40", {ic_req_pop, dir_rd_en}, dir_rd_addr); end
      @(posedge clk); #1 ic_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (gen_valid !== 1'b0) begin errors++; $display("FAIL miss_cyc1_gen: got %b expected 0", gen_valid); end
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest} !== {1'b1, 3'd3, 2'd1, 2'd3} || gen_addr !== 32'h40) begin
         errors++; $display("FAIL miss_issue: got v=%b op=%0d src=%0d dst=%0d addr=%h expected 1 3 1 3 40", gen_valid, gen_operation, gen_source, gen_dest, gen_addr); end
      @(negedge clk);
      checks++; if ({gen_valid, pend_valid} !== 2'b01) begin errors++; $display("FAIL miss_pend: got gv/pend=%b expected 01", {gen_valid, pend_valid}); end
   endtask

   task automatic test_rr();
      apply_reset();
      dir_rd_state = 4'b0100;
      @(negedge clk);
      ic_req_valid = 1'b1; ic_req_op = OP_RD; ic_req_addr = 32'h10;
      dc_req_valid = 1'b1; dc_req_op = OP_WR; dc_req_addr = 32'h20;
      #1;
      checks++; if ({ic_req_pop, dc_req_pop} !== 2'b10) begin errors++; $display("FAIL rr_first: got ic/dc pop=%b expected 10", {ic_req_pop, dc_req_pop}); end
      @(posedge clk); #1 ic_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest, gen_state} !== {1'b1, 3'd3, 2'd1, 2'd2, 4'b0100}) begin
         errors++; $display("FAIL rr_shared_rd: got v=%b op=%0d src=%0d dst=%0d st=%b expected 1 3 1 2 0100", gen_valid, gen_operation, gen_source, gen_dest, gen_state); end
      @(negedge clk);
      checks++; if ({dc_req_pop, pend_valid} !== 2'b10) begin errors++; $display("FAIL rr_second: got dcpop/pend=%b expected 10", {dc_req_pop, pend_valid}); end
      @(posedge clk); #1 dc_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest} !== {1'b1, 3'd4, 2'd2, 2'd3} || gen_addr !== 32'h20) begin
         errors++; $display("FAIL rr_dc_wr: got v=%b op=%0d src=%0d dst=%0d addr=%h expected 1 4 2 3 20", gen_valid, gen_operation, gen_source, gen_dest, gen_addr); end
   endtask

   task automatic test_reply();
      apply_reset();
      @(negedge clk);
      ic_req_valid = 1'b1; ic_req_op = OP_RD; ic_req_addr = 32'h40;
      @(posedge clk); #1 ic_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL reply_pend_set: got %b expected 1", pend_valid); end
      dc_req_valid = 1'b1; dc_req_op = OP_RD; dc_req_addr = 32'h80;
      #1;
      checks++; if (dc_req_pop !== 1'b0) begin errors++; $display("FAIL reply_rd_masked: got %b expected 0", dc_req_pop); end
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h40;
      #1;
      checks++; if ({mem_rsp_pop, dc_req_pop} !== 2'b10) begin errors++; $display("FAIL reply_priority: got mem/dc pop=%b expected 10", {mem_rsp_pop, dc_req_pop}); end
      @(posedge clk); #1 mem_rsp_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest} !== {1'b1, 3'd2, 2'd3, 2'd1} || gen_addr !== 32'h40) begin
         errors++; $display("FAIL reply_issue: got v=%b op=%0d src=%0d dst=%0d addr=%h expected 1 2 3 1 40", gen_valid, gen_operation, gen_source, gen_dest, gen_addr); end
      @(negedge clk);
      checks++; if ({pend_valid, dc_req_pop, err_stray} !== 3'b010) begin
         errors++; $display("FAIL reply_unmask: got pend/dcpop/stray=%b expected 010", {pend_valid, dc_req_pop, err_stray}); end
      @(posedge clk); #1 dc_req_op = OP_UPD;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest} !== {1'b1, 3'd3, 2'd2, 2'd3}) begin
         errors++; $display("FAIL reply_dc_miss: got v=%b op=%0d src=%0d dst=%0d expected 1 3 2 3", gen_valid, gen_operation, gen_source, gen_dest); end
      @(negedge clk);
      #1;
      checks++; if ({pend_valid, dc_req_pop, err_timeout} !== 3'b100) begin
         errors++; $display("FAIL reply_addr_mask: got pend/dcpop/tmo=%b expected 100", {pend_valid, dc_req_pop, err_timeout}); end
      dc_req_valid = 1'b0;
   endtask

   task automatic test_timeout();
      apply_reset();
      @(negedge clk);
      ic_req_valid = 1'b1; ic_req_op = OP_RWITM; ic_req_addr = 32'h100;
      @(posedge clk); #1 ic_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_dest} !== {1'b1, 3'd7, 2'd3}) begin
         errors++; $display("FAIL tmo_rwitm: got v=%b op=%0d dst=%0d expected 1 7 3", gen_valid, gen_operation, gen_dest); end
      @(negedge clk);
      checks++; if ({pend_valid, err_timeout} !== 2'b10) begin errors++; $display("FAIL tmo_start: got pend/tmo=%b expected 10", {pend_valid, err_timeout}); end
      repeat (7) @(negedge clk);
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0 at 7 cycles", err_timeout); end
      @(negedge clk);
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_at_limit: got %b expected 1 at 8 cycles", err_timeout); end
      repeat (5) @(negedge clk);
      checks++; if ({err_timeout, pend_valid} !== 2'b11) begin errors++; $display("FAIL tmo_sticky: got tmo/pend=%b expected 11", {err_timeout, pend_valid}); end
   endtask

   task automatic test_stray();
      apply_reset();
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_addr = 32'h99;
      #1;
      checks++; if ({mem_rsp_pop, dir_rd_en} !== 2'b11 || dir_rd_addr !== 32'h99) begin
         errors++; $display("FAIL stray_grant: got pop/en=%b addr=%h expected 11 99", {mem_rsp_pop, dir_rd_en}, dir_rd_addr); end
      @(posedge clk); #1 mem_rsp_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest, err_stray} !== {1'b1, 3'd2, 2'd3, 2'd0, 1'b0}) begin
         errors++; $display("FAIL stray_issue: got v=%b op=%0d src=%0d dst=%0d err=%b expected 1 2 3 0 0", gen_valid, gen_operation, gen_source, gen_dest, err_stray); end
      @(negedge clk);
      checks++; if ({err_stray, pend_valid} !== 2'b10) begin errors++; $display("FAIL stray_flag: got stray/pend=%b expected 10", {err_stray, pend_valid}); end
      repeat (4) @(negedge clk);
      checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b expected 1", err_stray); end
   endtask

   task automatic test_noop();
      int gv_count;
      apply_reset();
      @(negedge clk);
      ic_req_valid = 1'b1; ic_req_op = OP_NOOP; ic_req_addr = 32'h20;
      dc_req_valid = 1'b1; dc_req_op = OP_INV; dc_req_addr = 32'h30;
      #1;
      checks++; if ({ic_req_pop, dc_req_pop} !== 2'b10) begin errors++; $display("FAIL noop_pop: got ic/dc pop=%b expected 10", {ic_req_pop, dc_req_pop}); end
      @(posedge clk); #1 ic_req_valid = 1'b0;
      gv_count = 0;
      @(negedge clk); if (gen_valid) gv_count++;
      @(negedge clk); if (gen_valid) gv_count++;
      checks++; if (gv_count !== 0) begin errors++; $display("FAIL noop_no_issue: got %0d strobes expected 0", gv_count); end
      @(negedge clk);
      checks++; if (dc_req_pop !== 1'b1) begin errors++; $display("FAIL noop_next_grant: got %b expected 1", dc_req_pop); end
      @(posedge clk); #1 dc_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if ({gen_valid, gen_operation, gen_source, gen_dest} !== {1'b1, 3'd5, 2'd2, 2'd3}) begin
         errors++; $display("FAIL noop_inv: got v=%b op=%0d src=%0d dst=%0d expected 1 5 2 3", gen_valid, gen_operation, gen_source, gen_dest); end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_rr();
      test_reply();
      test_timeout();
      test_stray();
      test_noop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
